// File: rtl/cksum_ctrl_pkg.sv
// Shared types and constants for the length-framed byte checksum sequencer.
// The optional watchdog is enabled with CKSUM_TIMEOUT_EN.
package cksum_ctrl_pkg;

    localparam int unsigned CHAN_W = 7;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned RES_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Status byte bit positions
    localparam int unsigned STAT_DONE    = 0;
    localparam int unsigned STAT_STRAY   = 1;
    localparam int unsigned STAT_ABORT   = 2;
    localparam int unsigned STAT_TIMEOUT = 3;
    localparam int unsigned STAT_STATE   = 6;

    // Channel offsets from the block's base channel
    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_HI   = 2'd1;
    localparam logic [1:0] OFF_LO   = 2'd2;
    localparam logic [1:0] OFF_CMD  = 2'd3;

    localparam logic [BYTE_W-1:0] CMD_START = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_ABORT = 8'h02;

    function automatic logic [BYTE_W-1:0] make_status(
        input state_t st,
        input logic   err_timeout,
        input logic   err_abort,
        input logic   err_stray
    );
        logic [BYTE_W-1:0] s;
        s                       = '0;
        s[STAT_STATE +: 2]      = st;
        s[STAT_TIMEOUT]         = err_timeout;
        s[STAT_ABORT]           = err_abort;
        s[STAT_STRAY]           = err_stray;
        s[STAT_DONE]            = (st == ST_DONE);
        return s;
    endfunction

endpackage

// File: rtl/cksum_wdog.sv
// Idle-cycle watchdog: counts enabled cycles, reloads to zero whenever counting
// pauses, and pulses expired_c on the TIMEOUT-th consecutive enabled cycle.
// Only built when CKSUM_TIMEOUT_EN is defined.
`ifdef CKSUM_TIMEOUT_EN
module cksum_wdog
    import cksum_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    assign expired_c = count_en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || !count_en || expired_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/cksum_block_ctrl.sv
// Length-framed 16-bit byte checksum sequencer on a 4-channel host pipe window.
// Define CKSUM_TIMEOUT_EN to add the RUN-state idle watchdog.
module cksum_block_ctrl
    import cksum_ctrl_pkg::*;
#(
    parameter logic [CHAN_W-1:0] CHAN_BASE = 7'd0,
    parameter int unsigned       TIMEOUT   = 1024
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [CHAN_W-1:0] chanAddr_in,
    input  logic [BYTE_W-1:0] h2fData_in,
    input  logic              h2fValid_in,
    output logic              h2fReady_out,
    output logic [BYTE_W-1:0] f2hData_out,
    output logic              f2hValid_out,
    input  logic              f2hReady_in,
    output logic [RES_W-1:0]  result_out,
    output logic              busy_out,
    output logic              done_out
);

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   len, len_nxt;
    logic [LEN_W-1:0]   remaining, remaining_nxt;
    logic [RES_W-1:0]   result, result_nxt;
    logic               err_stray, err_stray_nxt;
    logic               err_abort, err_abort_nxt;
    logic               err_timeout, err_timeout_nxt;

    logic [7:0]         chan_diff;
    logic               chan_hit;
    logic [1:0]         off;
    logic               wr;
    logic               accept;
    logic               timeout_hit;

    // Window decode; channels below the base wrap to large values and miss
    assign chan_diff = 8'(chanAddr_in) - 8'(CHAN_BASE);
    assign chan_hit  = (chan_diff < 8'd4);
    assign off       = chan_diff[1:0];

    assign h2fReady_out = 1'b1;
    assign wr           = h2fValid_in && h2fReady_out && chan_hit;
    assign accept       = wr && (off == OFF_DATA) && (state == ST_RUN);

    assign result_out = result;
    assign busy_out   = (state == ST_RUN);
    assign done_out   = (state == ST_DONE);

`ifdef CKSUM_TIMEOUT_EN
    cksum_wdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_wdog (
        .clk       (clk_in),
        .rst       (reset_in),
        .count_en  ((state == ST_RUN) && !accept),
        .expired_c (timeout_hit)
    );
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Reads have no side effects, so the read strobe is not needed
    logic unused_read_strobe;
    assign unused_read_strobe = f2hReady_in;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state       <= ST_IDLE;
            len         <= '0;
            remaining   <= '0;
            result      <= '0;
            err_stray   <= 1'b0;
            err_abort   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            len         <= len_nxt;
            remaining   <= remaining_nxt;
            result      <= result_nxt;
            err_stray   <= err_stray_nxt;
            err_abort   <= err_abort_nxt;
            err_timeout <= err_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        len_nxt         = len;
        remaining_nxt   = remaining;
        result_nxt      = result;
        err_stray_nxt   = err_stray;
        err_abort_nxt   = err_abort;
        err_timeout_nxt = err_timeout;

        if (wr) begin
            unique case (off)
                OFF_DATA: begin
                    if (state == ST_RUN) begin
                        result_nxt    = result + RES_W'(h2fData_in);
                        remaining_nxt = remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state_nxt = ST_DONE;
                        end
                    end else begin
                        err_stray_nxt = 1'b1;
                    end
                end
                OFF_HI: begin
                    if (state == ST_RUN) begin
                        err_stray_nxt = 1'b1;
                    end else begin
                        len_nxt[15:8] = h2fData_in;
                    end
                end
                OFF_LO: begin
                    if (state == ST_RUN) begin
                        err_stray_nxt = 1'b1;
                    end else begin
                        len_nxt[7:0] = h2fData_in;
                    end
                end
                OFF_CMD: begin
                    if (h2fData_in == CMD_START) begin
                        if (state == ST_RUN) begin
                            err_stray_nxt = 1'b1;
                        end else begin
                            result_nxt      = '0;
                            remaining_nxt   = len;
                            err_stray_nxt   = 1'b0;
                            err_abort_nxt   = 1'b0;
                            err_timeout_nxt = 1'b0;
                            state_nxt       = (len == '0) ? ST_DONE : ST_RUN;
                        end
                    end else if (h2fData_in == CMD_ABORT) begin
                        state_nxt     = ST_IDLE;
                        err_abort_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Watchdog fires only on a cycle without a data accept
        if (timeout_hit) begin
            state_nxt       = ST_IDLE;
            err_timeout_nxt = 1'b1;
        end
    end

    // Zero-latency read mux; result bytes stall while a frame is in flight
    always_comb begin
        f2hData_out  = '0;
        f2hValid_out = 1'b1;
        if (chan_hit) begin
            unique case (off)
                OFF_DATA: f2hData_out = make_status(state, err_timeout, err_abort, err_stray);
                OFF_HI:   f2hData_out = result[15:8];
                OFF_LO:   f2hData_out = result[7:0];
                OFF_CMD:  f2hData_out = remaining[7:0];
                default:  f2hData_out = '0;
            endcase
            if (((off == OFF_HI) || (off == OFF_LO)) && (state == ST_RUN)) begin
                f2hValid_out = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cksum_block_ctrl.sv
// Scoreboard bench for cksum_block_ctrl: transaction-level model plus directed
// and random stimulus; a negedge monitor checks every host read cycle.
`timescale 1ns/1ps
module tb_cksum_block_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] chan = '0;
    logic [7:0] wdata = '0;
    logic       h2f_valid = 1'b0;
    logic       h2f_ready;
    logic [7:0] rdata;
    logic       f2h_valid;
    logic       f2h_ready = 1'b0;
    logic [15:0] result;
    logic       busy;
    logic       done;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    cksum_block_ctrl dut (
        .clk_in       (clk),
        .reset_in     (rst),
        .chanAddr_in  (chan),
        .h2fData_in   (wdata),
        .h2fValid_in  (h2f_valid),
        .h2fReady_out (h2f_ready),
        .f2hData_out  (rdata),
        .f2hValid_out (f2h_valid),
        .f2hReady_in  (f2h_ready),
        .result_out   (result),
        .busy_out     (busy),
        .done_out     (done)
    );

    // Reference model: frame-level view of the block
    int m_mode, m_len, m_rem, m_sum;
    bit m_stray, m_abort, m_tmo;

    function automatic void model_reset();
        m_mode = M_IDLE; m_len = 0; m_rem = 0; m_sum = 0;
        m_stray = 0; m_abort = 0; m_tmo = 0;
    endfunction

    function automatic void model_write(input int ch, input int d);
        if (ch > 3) return;
        case (ch)
            0: if (m_mode == M_RUN) begin
                   m_sum = (m_sum + d) % 65536;
                   m_rem = m_rem - 1;
                   if (m_rem == 0) m_mode = M_DONE;
               end else m_stray = 1;
            1: if (m_mode == M_RUN) m_stray = 1; else m_len = (m_len % 256) + d * 256;
            2: if (m_mode == M_RUN) m_stray = 1; else m_len = (m_len / 256) * 256 + d;
            default: begin
                if (d == 1) begin
                    if (m_mode == M_RUN) m_stray = 1;
                    else begin
                        m_sum = 0; m_rem = m_len;
                        m_stray = 0; m_abort = 0; m_tmo = 0;
                        m_mode = (m_len == 0) ? M_DONE : M_RUN;
                    end
                end else if (d == 2) begin
                    m_mode = M_IDLE; m_abort = 1;
                end
            end
        endcase
    endfunction

    function automatic int model_read(input int ch);
        case (ch)
            0: return m_mode * 64 + m_tmo * 8 + m_abort * 4 + m_stray * 2 + ((m_mode == M_DONE) ? 1 : 0);
            1: return m_sum / 256;
            2: return m_sum % 256;
            3: return m_rem % 256;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_valid(input int ch);
        return !((m_mode == M_RUN) && (ch == 1 || ch == 2));
    endfunction

    typedef struct {
        int          ch;
        bit          valid;
        logic [7:0]  data;
        logic [15:0] res;
        bit          busy;
        bit          done;
    } exp_t;

    exp_t exp_q[$];

    function automatic void chk(input string nm, input int ch, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s ch=%0d got=%h exp=%h t=%0t", nm, ch, got, exp, $time);
        end
    endfunction

    // Monitor: one expected item per host read cycle
    always @(negedge clk) begin
        if (f2h_ready) begin
            if (exp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL scoreboard_empty ch=%0d got=read exp=none", chan);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_valid", e.ch, 16'(f2h_valid), 16'(e.valid));
                if (e.valid) chk("rd_data", e.ch, 16'(rdata), 16'(e.data));
                chk("result_out", e.ch, result, e.res);
                chk("busy_out", e.ch, 16'(busy), 16'(e.busy));
                chk("done_out", e.ch, 16'(done), 16'(e.done));
                chk("h2f_ready", e.ch, 16'(h2f_ready), 16'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input int ch, input int d);
        chan = 7'(ch); wdata = 8'(d); h2f_valid = 1'b1;
        model_write(ch, d);
        tick();
        h2f_valid = 1'b0;
    endtask

    task automatic push_rd(input int ch, input bit valid, input int data);
        exp_t e;
        e.ch = ch; e.valid = valid; e.data = 8'(data);
        e.res = 16'(m_sum); e.busy = (m_mode == M_RUN); e.done = (m_mode == M_DONE);
        exp_q.push_back(e);
        chan = 7'(ch); f2h_ready = 1'b1;
        tick();
        f2h_ready = 1'b0;
    endtask

    task automatic rd(input int ch);
        push_rd(ch, model_valid(ch), model_read(ch));
    endtask

    task automatic rd_k(input int ch, input int data, input bit valid);
        push_rd(ch, valid, data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        rd_k(0, 8'h00, 1); rd_k(1, 8'h00, 1); rd_k(2, 8'h00, 1); rd_k(3, 8'h00, 1);
        rd_k(9, 8'h00, 1);

        // Basic frame
        wr(1, 8'h00); wr(2, 8'h03); wr(3, 8'h01);
        wr(0, 8'h10); wr(0, 8'h20); wr(0, 8'hFF);
        rd_k(0, 8'h81, 1); rd_k(1, 8'h01, 1); rd_k(2, 8'h2F, 1); rd_k(3, 8'h00, 1);

        // Preload result to 0xFFFF, then START must zero it; result reads stall in RUN
        wr(1, 8'h01); wr(2, 8'h01); wr(3, 8'h01);
        for (int i = 0; i < 257; i++) wr(0, 8'hFF);
        rd_k(1, 8'hFF, 1); rd_k(2, 8'hFF, 1);
        wr(1, 8'h00); wr(2, 8'h02); wr(3, 8'h01);
        rd_k(1, 8'h00, 0); rd_k(0, 8'h40, 1);
        wr(0, 8'hFF);
        rd_k(2, 8'h00, 0); rd_k(3, 8'h01, 1); rd_k(1, 8'h00, 0);
        wr(0, 8'hFF);
        rd_k(1, 8'h01, 1); rd_k(2, 8'hFE, 1); rd_k(0, 8'h81, 1);

        // Zero-length frame and stray data
        wr(2, 8'h00); wr(3, 8'h01);
        rd_k(0, 8'h81, 1); rd_k(1, 8'h00, 1); rd_k(2, 8'h00, 1);
        wr(0, 8'h55);
        rd_k(0, 8'h83, 1); rd_k(2, 8'h00, 1);

        // Abort mid-frame holds result and remaining
        wr(2, 8'h05); wr(3, 8'h01);
        rd_k(0, 8'h40, 1);
        wr(0, 8'h01); wr(0, 8'h02); wr(3, 8'h02);
        rd_k(0, 8'h04, 1); rd_k(3, 8'h03, 1); rd_k(2, 8'h03, 1);

        // Reset mid-frame clears everything, including len
        wr(3, 8'h01); wr(0, 8'h77);
        do_reset();
        rd_k(0, 8'h00, 1); rd_k(1, 8'h00, 1); rd_k(2, 8'h00, 1); rd_k(3, 8'h00, 1);
        wr(3, 8'h01);
        rd_k(0, 8'h81, 1);

`ifdef CKSUM_TIMEOUT_EN
        // Watchdog abandons a stalled frame
        wr(2, 8'h04); wr(3, 8'h01); wr(0, 8'h11);
        repeat (1030) tick();
        m_mode = M_IDLE; m_tmo = 1;
        rd_k(0, 8'h08, 1); rd_k(2, 8'h11, 1);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 45)      wr(0, $urandom_range(0, 255));
            else if (r < 50) wr(1, 0);
            else if (r < 58) wr(2, $urandom_range(0, 6));
            else if (r < 67) wr(3, 1);
            else if (r < 70) wr(3, 2);
            else if (r < 72) wr(3, $urandom_range(3, 255));
            else if (r < 75) wr($urandom_range(4, 127), $urandom_range(0, 255));
            else begin
                int c;
                c = $urandom_range(0, 4);
                rd((c == 4) ? $urandom_range(4, 127) : c);
            end
        end

        rd(0); rd(1); rd(2); rd(3);
        tick(); tick();
        chk("queue_drained", 0, 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
